// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request, IF/ID register.
// One-entry stall buffer and a drop state for stale responses.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pipeline,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic        valid_id
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        valid_id_q, valid_id_d;
    logic [31:0] target;

    assign target    = {redirect_target[31:2], 2'b00};
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign instr_id  = instr_id_q;
    assign pc_id     = pc_id_q;
    assign valid_id  = valid_id_q;

    // Next-state, IF/ID and request logic; redirect outranks stall everywhere
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pending_d   = pending_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        instr_id_d  = instr_id_q;
        pc_id_d     = pc_id_q;
        valid_id_d  = valid_id_q;
        imem_req    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    instr_id_d  = NOP_INSTR;
                    valid_id_d  = 1'b0;
                    buf_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = target;
                    end else begin
                        pending_d = target;
                        state_d   = S_DROP;
                    end
                end else if (imem_ready && !stall_pipeline) begin
                    instr_id_d = imem_rdata;
                    pc_id_d    = imem_addr;
                    valid_id_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end else if (imem_ready) begin
                    buf_instr_d = imem_rdata;
                    buf_pc_d    = imem_addr;
                    buf_valid_d = 1'b1;
                    pc_d        = pc_q + 32'd4;
                    state_d     = S_HOLD;
                end else if (!stall_pipeline) begin
                    instr_id_d = NOP_INSTR;
                    valid_id_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    buf_valid_d = 1'b0;
                    instr_id_d  = NOP_INSTR;
                    valid_id_d  = 1'b0;
                    pc_d        = target;
                    state_d     = S_FETCH;
                end else if (!stall_pipeline) begin
                    instr_id_d  = buf_instr_q;
                    pc_id_d     = buf_pc_q;
                    valid_id_d  = 1'b1;
                    buf_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_DROP: begin
                imem_req   = 1'b1;
                instr_id_d = NOP_INSTR;
                valid_id_d = 1'b0;
                if (redirect_valid) begin
                    pending_d = target;
                    if (imem_ready) begin
                        pc_d    = target;
                        state_d = S_FETCH;
                    end
                end else if (imem_ready) begin
                    pc_d    = pending_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            pending_q   <= 32'd0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 32'd0;
            buf_valid_q <= 1'b0;
            instr_id_q  <= NOP_INSTR;
            pc_id_q     <= 32'd0;
            valid_id_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
            instr_id_q  <= instr_id_d;
            pc_id_q     <= pc_id_d;
            valid_id_q  <= valid_id_d;
        end
    end

endmodule
